// File: rtl/dmem_responder.sv
// Data-memory target: synchronous RAM below DEPTH plus an MMIO window holding
// a TX byte FIFO, a sticky status register and a free-running cycle counter.
module dmem_responder #(
  parameter int          DEPTH      = 4096,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_F000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        err_flag
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   r_mem [DEPTH];
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [31:0]   r_ram_rd;
  logic [31:0]   r_mmio_q;
  logic          r_sel_ram;
  logic [31:0]   r_cycles;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_err;
  logic          r_drop;

  logic          w_is_ram, w_is_tx, w_is_st, w_is_cyc, w_unmapped;
  logic          w_empty, w_full, w_push, w_pop, w_push_ok;
  logic [AW-1:0] w_ram_addr;
  logic [7:0]    w_cnt8;
  logic [31:0]   w_status;

  assign w_is_ram   = address_dmem < 32'(DEPTH);
  assign w_is_tx    = address_dmem == MMIO_BASE;
  assign w_is_st    = address_dmem == MMIO_BASE + 32'd1;
  assign w_is_cyc   = address_dmem == MMIO_BASE + 32'd2;
  assign w_unmapped = !(w_is_ram || w_is_tx || w_is_st || w_is_cyc);
  assign w_ram_addr = address_dmem[AW-1:0];

  assign w_empty   = r_count == '0;
  assign w_full    = r_count == CW'(FIFO_DEPTH);
  assign w_pop     = !w_empty && out_ready;
  assign w_push    = wren && w_is_tx;
  // A pop in the same edge frees the slot, so a full FIFO can still accept.
  assign w_push_ok = w_push && (!w_full || w_pop);

  assign w_cnt8   = 8'(r_count);
  assign w_status = {20'd0, w_cnt8, r_drop, r_err, w_full, w_empty};

  assign q_dmem    = r_sel_ram ? r_ram_rd : r_mmio_q;
  assign out_valid = !w_empty;
  assign out_data  = w_empty ? 8'd0 : r_fifo[r_rptr];
  assign err_flag  = r_err;

  // Storage arrays carry no reset; reset only blocks their writes.
  always_ff @(posedge clock) begin
    r_ram_rd <= r_mem[w_ram_addr];
    if (!reset && wren && w_is_ram) r_mem[w_ram_addr] <= data;
    if (!reset && w_push_ok)        r_fifo[r_wptr]    <= data[7:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sel_ram <= 1'b0;
      r_mmio_q  <= '0;
      r_cycles  <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_err     <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      r_sel_ram <= w_is_ram;
      if (w_is_st)       r_mmio_q <= w_status;
      else if (w_is_cyc) r_mmio_q <= r_cycles;
      else               r_mmio_q <= '0;

      r_cycles <= (wren && w_is_cyc) ? data : r_cycles + 32'd1;

      if (w_push_ok) r_wptr <= r_wptr + PW'(1);
      if (w_pop)     r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + CW'(w_push_ok) - CW'(w_pop);

      if (wren && w_is_st && data[0]) begin
        r_err  <= 1'b0;
        r_drop <= 1'b0;
      end else begin
        if (w_unmapped)            r_err  <= 1'b1;
        if (w_push && !w_push_ok)  r_drop <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed and random stimulus for dmem_responder, scored every cycle against
// a transaction-level model (assoc-array RAM, byte queue FIFO, integer counter).
module tb_dmem_responder;
  localparam int          DEPTH = 4096;
  localparam logic [31:0] MB    = 32'h0000_F000;
  localparam int          FD    = 8;
  localparam logic [31:0] TX = MB, ST = MB + 1, CY = MB + 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address_dmem = TX;
  logic [31:0] data = '0;
  logic        wren = 1'b0;
  logic [31:0] q_dmem;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        err_flag;

  dmem_responder #(.DEPTH(DEPTH), .MMIO_BASE(MB), .FIFO_DEPTH(FD)) dut (
    .clock(clock), .reset(reset), .address_dmem(address_dmem), .data(data),
    .wren(wren), .q_dmem(q_dmem), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .err_flag(err_flag)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  logic [31:0] m_mem [int];
  logic [7:0]  m_q [$];
  logic [31:0] m_cyc = 0;
  logic [31:0] m_qd = 0;
  logic        m_qd_known = 1'b1;
  logic        m_err = 0, m_drop = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [31:0] a, input logic [31:0] d, input logic w,
                       input logic rdy, input logic rst);
    logic full, pop, push;
    if (rst) begin
      m_qd = 0; m_qd_known = 1; m_cyc = 0; m_q.delete(); m_err = 0; m_drop = 0;
      return;
    end
    m_qd_known = 1;
    if (a < DEPTH) begin
      if (m_mem.exists(int'(a))) m_qd = m_mem[int'(a)];
      else m_qd_known = 0;
    end else if (a == ST)
      m_qd = {20'd0, 8'(m_q.size()), m_drop, m_err, m_q.size() == FD, m_q.size() == 0};
    else if (a == CY) m_qd = m_cyc;
    else m_qd = 0;

    full = (m_q.size() == FD);
    pop  = (m_q.size() > 0) && rdy;
    push = w && (a == TX);
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (!full || pop) m_q.push_back(d[7:0]);
      else m_drop = 1;
    end
    if (a >= DEPTH && a != TX && a != ST && a != CY) m_err = 1;
    if (w && a == ST && d[0]) begin m_err = 0; m_drop = 0; end
    m_cyc = (w && a == CY) ? d : m_cyc + 1;
    if (w && a < DEPTH) m_mem[int'(a)] = d;
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w,
                      input logic rdy, input logic rst);
    @(negedge clock);
    address_dmem = a; data = d; wren = w; out_ready = rdy; reset = rst;
    @(posedge clock);
    model(a, d, w, rdy, rst);
    #1;
    if (m_qd_known) chk("q_dmem", q_dmem, m_qd);
    chk("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
    chk("out_data", 32'(out_data), m_q.size() > 0 ? 32'(m_q[0]) : 32'd0);
    chk("err_flag", 32'(err_flag), 32'(m_err));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(TX, 0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] a, d;
    int sel;

    step(TX, 0, 0, 0, 1);
    step(TX, 0, 0, 0, 1);
    chk("rst_q", q_dmem, 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_err", 32'(err_flag), 0);

    idle(10);
    step(CY, 0, 0, 0, 0);
    chk("cyc10", q_dmem, 32'd10);

    step(32'd5, 32'hDEAD_BEEF, 1, 0, 0);
    step(32'd5, 0, 0, 0, 0);
    chk("ram_rt", q_dmem, 32'hDEAD_BEEF);
    step(32'd5, 32'd7, 1, 0, 0);
    chk("ram_rdw_old", q_dmem, 32'hDEAD_BEEF);
    step(32'd5, 0, 0, 0, 0);
    chk("ram_rdw_new", q_dmem, 32'd7);

    step(CY, 32'hFFFF_FFFE, 1, 0, 0);
    idle(2);
    step(CY, 0, 0, 0, 0);
    chk("cyc_wrap", q_dmem, 32'd0);

    for (int i = 1; i <= 9; i++) step(TX, 32'(i), 1, 0, 0);
    step(ST, 0, 0, 0, 0);
    chk("fill_cnt", 32'(q_dmem[11:4]), 32'd8);
    chk("fill_full", 32'(q_dmem[1]), 1);
    chk("fill_drop", 32'(q_dmem[3]), 1);
    chk("fill_head", 32'(out_data), 32'd1);
    step(ST, 32'd1, 1, 0, 0);
    step(ST, 0, 0, 0, 0);
    chk("drop_clr", 32'(q_dmem[3]), 0);

    for (int i = 1; i <= 8; i++) begin
      chk("drain_byte", 32'(out_data), 32'(i));
      step(TX, 0, 0, 1, 0);
    end
    chk("drain_valid", 32'(out_valid), 0);
    step(ST, 0, 0, 0, 0);
    chk("drain_empty", 32'(q_dmem[0]), 1);

    for (int i = 10; i < 18; i++) step(TX, 32'(i), 1, 0, 0);
    step(TX, 32'hAA, 1, 1, 0);
    step(ST, 0, 0, 0, 0);
    chk("fullpp_cnt", 32'(q_dmem[11:4]), 32'd8);
    chk("fullpp_drop", 32'(q_dmem[3]), 0);
    for (int i = 0; i < 7; i++) step(TX, 0, 0, 1, 0);
    chk("fullpp_last", 32'(out_data), 32'hAA);
    step(TX, 0, 0, 1, 0);

    step(32'h0001_0000, 0, 0, 0, 0);
    chk("unmap_q", q_dmem, 0);
    chk("unmap_err", 32'(err_flag), 1);

    step(TX, 32'h55, 1, 0, 0);
    step(TX, 32'h66, 1, 0, 1);
    chk("rst_mid_valid", 32'(out_valid), 0);
    chk("rst_mid_err", 32'(err_flag), 0);
    step(CY, 0, 0, 0, 0);
    chk("rst_mid_cyc", q_dmem, 0);

    for (int i = 0; i < 16; i++) step(32'(i), $urandom, 1, 0, 0);
    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 19);
      d = $urandom;
      if (sel < 5)       a = 32'($urandom_range(0, 15));
      else if (sel < 11) a = TX;
      else if (sel < 15) a = ST;
      else if (sel < 17) a = CY;
      else if (sel < 18) a = MB + 3;
      else               a = (sel == 18) ? 32'(DEPTH) : 32'hFFFF_FFFF;
      if (a == ST && $urandom_range(0, 3) != 0) d[0] = 1'b0;
      step(a, d, ($urandom_range(0, 2) != 0) && !(a == CY && $urandom_range(0, 3) != 0),
           $urandom_range(0, 2) == 0, $urandom_range(0, 99) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
